// File: rtl/bp_update_queue_if.sv
// Resolve-side and counter-table-side signals of the branch update queue.
// Master drives outcomes and table readiness; slave is the queue itself.
interface bp_update_queue_if #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_index;
  logic              res_taken;
  logic              upd_ready;
  logic              update;
  logic [IDX_W-1:0]  upd_index;
  logic              taken;
  logic [HIST_W-1:0] ghr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output res_valid, res_index, res_taken, upd_ready,
    input  res_ready, update, upd_index, taken, ghr, count, full, empty
  );

  modport slave (
    input  res_valid, res_index, res_taken, upd_ready,
    output res_ready, update, upd_index, taken, ghr, count, full, empty
  );
endinterface

// File: rtl/bp_update_queue.sv
// Queues resolved branches and issues one registered UPDATE pulse per entry (>=1 cycle after push, max 1 per 2 cycles);
// res_ready drops only when full, issue stalls while upd_ready is low or a pulse is already high.
module bp_update_queue #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bp_update_queue_if.slave   bus_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              update_q, update_d;
  logic [IDX_W-1:0]  upd_index_q, upd_index_d;
  logic              taken_q, taken_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              full, empty, push, issue;
  entry_t            head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus_if.res_valid && !full;
  // Blocking on update_q guarantees a low cycle between pulses, so every update gets its own rising edge.
  assign issue = !empty && bus_if.upd_ready && !update_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    update_d    = issue;
    upd_index_d = upd_index_q;
    taken_d     = taken_q;
    ghr_d       = ghr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      upd_index_d = head.idx;
      taken_d     = head.taken;
      ghr_d       = {ghr_q[HIST_W-2:0], head.taken};
    end
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      update_q    <= 1'b0;
      upd_index_q <= '0;
      taken_q     <= 1'b0;
      ghr_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      update_q    <= update_d;
      upd_index_q <= upd_index_d;
      taken_q     <= taken_d;
      ghr_q       <= ghr_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= '{idx: bus_if.res_index, taken: bus_if.res_taken};
    end
  end

  assign bus_if.res_ready = !full;
  assign bus_if.update    = update_q;
  assign bus_if.upd_index = upd_index_q;
  assign bus_if.taken     = taken_q;
  assign bus_if.ghr       = ghr_q;
  assign bus_if.count     = count_q;
  assign bus_if.full      = full;
  assign bus_if.empty     = empty;
endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: vector table for the cycle-exact basics, scoreboard
// monitor on every falling edge for ordering, timing, COUNT and GHR.
module tb_bp_update_queue;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 6;
  localparam int HIST_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bp_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

  bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .HIST_W(HIST_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [IDX_W-1:0] i,
                       input logic t, input logic u);
    rst           = r;
    bus.res_valid = v;
    bus.res_index = i;
    bus.res_taken = t;
    bus.upd_ready = u;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state as it should be after the most recent rising edge
  logic [IDX_W:0]    sb[$];
  logic              m_update = 1'b0;
  logic [IDX_W-1:0]  m_idx = '0;
  logic              m_taken = 1'b0;
  logic [HIST_W-1:0] m_ghr = '0;
  bit                m_ok = 1'b0;
  logic              prev_update = 1'b0;

  always @(negedge clk) begin
    logic           iss, psh;
    logic [IDX_W:0] e;
    if (m_ok) begin
      chk("mon_update", bus.update, m_update);
      chk("mon_upd_index", bus.upd_index, m_idx);
      chk("mon_taken", bus.taken, m_taken);
      chk("mon_ghr", bus.ghr, m_ghr);
      chk("mon_count", bus.count, sb.size());
      chk("mon_empty", bus.empty, sb.size() == 0);
      chk("mon_full", bus.full, sb.size() == DEPTH);
      chk("mon_res_ready", bus.res_ready, sb.size() != DEPTH);
      chk("mon_no_back_to_back", bus.update & prev_update, 1'b0);
    end
    prev_update = bus.update;
    if (rst) begin
      sb.delete();
      m_update = 1'b0;
      m_idx    = '0;
      m_taken  = 1'b0;
      m_ghr    = '0;
      m_ok     = 1'b1;
    end else begin
      iss = (sb.size() > 0) && bus.upd_ready && !m_update;
      psh = bus.res_valid && (sb.size() < DEPTH);
      if (iss) begin
        e       = sb.pop_front();
        m_idx   = e[IDX_W:1];
        m_taken = e[0];
        m_ghr   = {m_ghr[HIST_W-2:0], e[0]};
      end
      m_update = iss;
      if (psh) sb.push_back({bus.res_index, bus.res_taken});
    end
  end

  typedef struct {
    logic             r, v;
    logic [IDX_W-1:0] i;
    logic             t, u;
    logic             e_upd;
    logic [2:0]       e_cnt;
    logic [IDX_W-1:0] e_idx;
    logic             e_tkn;
    logic [HIST_W-1:0] e_ghr;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [IDX_W-1:0] i, logic t, logic u,
                              logic eu, logic [2:0] ec, logic [IDX_W-1:0] ei,
                              logic et, logic [HIST_W-1:0] eg);
    vec_t x;
    x.r = r; x.v = v; x.i = i; x.t = t; x.u = u;
    x.e_upd = eu; x.e_cnt = ec; x.e_idx = ei; x.e_tkn = et; x.e_ghr = eg;
    return x;
  endfunction

  task automatic drain(input string nm);
    for (int n = 0; n < 60 && (sb.size() != 0 || bus.update); n++) cyc();
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    vec_t tv[16];
    bit   saw_full, saw_rdy0, saw_rdy1;

    //          r  v  idx    t  u    upd cnt idx    t  ghr
    tv[0]  = mk(1, 0, 6'h00, 0, 0,   0,  0,  6'h00, 0, 4'b0000);
    tv[1]  = mk(1, 0, 6'h00, 0, 1,   0,  0,  6'h00, 0, 4'b0000);
    tv[2]  = mk(0, 1, 6'h15, 1, 1,   0,  1,  6'h00, 0, 4'b0000);
    tv[3]  = mk(0, 0, 6'h00, 0, 1,   1,  0,  6'h15, 1, 4'b0001);
    tv[4]  = mk(0, 0, 6'h00, 0, 1,   0,  0,  6'h15, 1, 4'b0001);
    tv[5]  = mk(0, 1, 6'h0A, 0, 1,   0,  1,  6'h15, 1, 4'b0001);
    tv[6]  = mk(0, 1, 6'h0B, 1, 1,   1,  1,  6'h0A, 0, 4'b0010);
    tv[7]  = mk(0, 1, 6'h0C, 0, 1,   0,  2,  6'h0A, 0, 4'b0010);
    tv[8]  = mk(0, 1, 6'h0D, 1, 1,   1,  2,  6'h0B, 1, 4'b0101);
    tv[9]  = mk(0, 0, 6'h00, 0, 0,   0,  2,  6'h0B, 1, 4'b0101);
    tv[10] = mk(0, 0, 6'h00, 0, 1,   1,  1,  6'h0C, 0, 4'b1010);
    tv[11] = mk(0, 0, 6'h00, 0, 1,   0,  1,  6'h0C, 0, 4'b1010);
    tv[12] = mk(0, 0, 6'h00, 0, 1,   1,  0,  6'h0D, 1, 4'b0101);
    tv[13] = mk(0, 1, 6'h3F, 1, 1,   0,  1,  6'h0D, 1, 4'b0101);
    tv[14] = mk(1, 1, 6'h2A, 1, 1,   0,  0,  6'h00, 0, 4'b0000);
    tv[15] = mk(0, 0, 6'h00, 0, 1,   0,  0,  6'h00, 0, 4'b0000);

    drive(1, 0, '0, 0, 0);
    cyc();
    for (int k = 0; k < 16; k++) begin
      drive(tv[k].r, tv[k].v, tv[k].i, tv[k].t, tv[k].u);
      cyc();
      chk($sformatf("vec%0d_update", k), bus.update, tv[k].e_upd);
      chk($sformatf("vec%0d_count", k), bus.count, tv[k].e_cnt);
      chk($sformatf("vec%0d_upd_index", k), bus.upd_index, tv[k].e_idx);
      chk($sformatf("vec%0d_taken", k), bus.taken, tv[k].e_tkn);
      chk($sformatf("vec%0d_ghr", k), bus.ghr, tv[k].e_ghr);
    end

    // Reset held two cycles after three stalled pushes
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, IDX_W'(k + 8), 1, 0);
      cyc();
    end
    drive(1, 0, '0, 0, 1); cyc(); cyc();
    drive(0, 0, '0, 0, 1); cyc();
    chk("rst_mid_update", bus.update, 0);
    chk("rst_mid_count", bus.count, 0);
    chk("rst_mid_empty", bus.empty, 1);
    chk("rst_mid_ghr", bus.ghr, 0);
    for (int k = 0; k < 4; k++) cyc();

    // Fill to full with table stalled; fifth push must be dropped
    drive(0, 1, 6'd1, 1, 0); cyc();
    drive(0, 1, 6'd2, 0, 0); cyc();
    drive(0, 1, 6'd3, 1, 0); cyc();
    drive(0, 1, 6'd4, 1, 0); cyc();
    chk("fill_full", bus.full, 1);
    chk("fill_res_ready", bus.res_ready, 0);
    drive(0, 1, 6'd5, 0, 0); cyc();
    chk("fill_count_hold", bus.count, DEPTH);
    drive(0, 0, '0, 0, 1);
    drain("fill_drain");
    chk("fill_ghr", bus.ghr, 4'b1011);
    chk("fill_last_idx", bus.upd_index, 6'd4);

    // Continuous push with table always ready
    saw_full = 0; saw_rdy0 = 0; saw_rdy1 = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, IDX_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1);
      cyc();
      if (bus.full) saw_full = 1;
      if (bus.res_ready) saw_rdy1 = 1; else saw_rdy0 = 1;
    end
    chk("stream_saturates", saw_full, 1);
    chk("stream_ready_toggles", saw_rdy0 & saw_rdy1, 1);
    drive(0, 0, '0, 0, 1);
    drain("stream_drain");

    // Stall with three queued for five cycles, then resume
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, IDX_W'(k + 40), 1'(k), 0);
      cyc();
    end
    drive(0, 0, '0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_no_update", bus.update, 0);
      chk("stall_count", bus.count, 3);
    end
    drive(0, 0, '0, 0, 1); cyc();
    chk("stall_resume_update", bus.update, 1);
    chk("stall_resume_idx", bus.upd_index, 6'd40);
    drain("stall_drain");

    // Random traffic with occasional reset
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
            IDX_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      cyc();
    end
    drive(0, 0, '0, 0, 1);
    drain("random_drain");
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
